// File: rtl/dac_chan_fmt.sv
// N-lane DAC sample formatter: shift, saturate and offset-binary convert signed
// FIR samples, with per-lane square/ramp/mid-scale test modes behind a 3-stage pipeline.
module dac_chan_fmt #(
    parameter int NCH   = 2,
    parameter int IN_W  = 16,
    parameter int DAC_W = 14,
    parameter int SHIFT = 2,
    parameter int UR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [NCH*IN_W-1:0]   in_data,
    input  logic [NCH-1:0]        bit_in,
    input  logic [2*NCH-1:0]      mode,
    input  logic                  sat_clr,
    output logic [NCH*DAC_W-1:0]  dac_data,
    output logic                  dac_valid,
    output logic [NCH-1:0]        sat_flag,
    output logic [UR_W-1:0]       underrun_cnt
);
    localparam logic [DAC_W-1:0]       MID  = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic signed [IN_W-1:0] SMAX = IN_W'((2**(DAC_W-1)) - 1);
    localparam logic signed [IN_W-1:0] SMIN = IN_W'(-(2**(DAC_W-1)));

    // Valid semantics: in_valid qualifies in_data for one cycle, there is no
    // backpressure; dac_valid marks the single cycle in which dac_data took a new sample.

    logic                 w_no_filt;
    logic                 r1_valid;
    logic                 r1_en;
    logic [NCH*IN_W-1:0]  r1_data;
    logic [NCH-1:0]       r1_bit;
    logic [2*NCH-1:0]     r1_mode;

    // Without a filtered lane nothing waits on the FIR, so every cycle is valid.
    always_comb begin
        w_no_filt = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (mode[2*k +: 2] == 2'b00) w_no_filt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_en    <= 1'b0;
            r1_data  <= '0;
            r1_bit   <= '0;
            r1_mode  <= '0;
        end else begin
            r1_valid <= in_valid | w_no_filt;
            r1_en    <= en;
            r1_data  <= in_data;
            r1_bit   <= bit_in;
            r1_mode  <= mode;
        end
    end

    logic signed [IN_W-1:0] w_shf [NCH];
    logic [DAC_W-1:0]       w_s   [NCH];
    logic [NCH-1:0]         w_set;

    always_comb begin
        w_set = '0;
        for (int k = 0; k < NCH; k++) begin
            w_shf[k] = $signed(r1_data[k*IN_W +: IN_W]) >>> SHIFT;
            if (w_shf[k] > SMAX) begin
                w_s[k]   = SMAX[DAC_W-1:0];
                w_set[k] = r1_valid & (r1_mode[2*k +: 2] == 2'b00);
            end else if (w_shf[k] < SMIN) begin
                w_s[k]   = SMIN[DAC_W-1:0];
                w_set[k] = r1_valid & (r1_mode[2*k +: 2] == 2'b00);
            end else begin
                w_s[k]   = w_shf[k][DAC_W-1:0];
            end
        end
    end

    logic                 r2_valid;
    logic                 r2_en;
    logic [NCH*DAC_W-1:0] r2_s;
    logic [NCH-1:0]       r2_bit;
    logic [2*NCH-1:0]     r2_mode;
    logic [NCH-1:0]       r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_en    <= 1'b0;
            r2_s     <= '0;
            r2_bit   <= '0;
            r2_mode  <= '0;
            r_sat    <= '0;
        end else begin
            r2_valid <= r1_valid;
            r2_en    <= r1_en;
            for (int k = 0; k < NCH; k++) r2_s[k*DAC_W +: DAC_W] <= w_s[k];
            r2_bit   <= r1_bit;
            r2_mode  <= r1_mode;
            r_sat    <= (r_sat & ~{NCH{sat_clr}}) | w_set;
        end
    end

    logic [NCH*DAC_W-1:0] w_code;
    logic [DAC_W-1:0]     r_ramp;
    logic [NCH*DAC_W-1:0] r_dac;
    logic                 r_dv;
    logic [UR_W-1:0]      r_ur;

    always_comb begin
        w_code = '0;
        for (int k = 0; k < NCH; k++) begin
            case (r2_mode[2*k +: 2])
                2'b00:   w_code[k*DAC_W +: DAC_W] = {~r2_s[(k+1)*DAC_W-1], r2_s[k*DAC_W +: DAC_W-1]};
                2'b01:   w_code[k*DAC_W +: DAC_W] = r2_bit[k] ? {DAC_W{1'b1}} : MID;
                2'b10:   w_code[k*DAC_W +: DAC_W] = r_ramp;
                default: w_code[k*DAC_W +: DAC_W] = MID;
            endcase
        end
    end

    // A non-valid enabled cycle can only come from a starved filtered lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dac  <= {NCH{MID}};
            r_dv   <= 1'b0;
            r_ramp <= '0;
            r_ur   <= '0;
        end else begin
            r_dv <= r2_valid & r2_en;
            if (!r2_en) begin
                r_dac <= {NCH{MID}};
            end else if (r2_valid) begin
                r_dac  <= w_code;
                r_ramp <= r_ramp + 1'b1;
            end else if (r_ur != {UR_W{1'b1}}) begin
                r_ur <= r_ur + 1'b1;
            end
        end
    end

    assign dac_data     = r_dac;
    assign dac_valid    = r_dv;
    assign sat_flag     = r_sat;
    assign underrun_cnt = r_ur;
endmodule
